uart_fifo: RTL and testbench
============================

// Module: uart_fifo
// PURPOSE
//  Parametrised UART, next generation of the NX4 uart: configurable data bits, parity and stop bits.
//  TX and RX FIFOs decouple host logic from line timing.
//  Each received byte carries per-byte parity/framing error flags; RX overrun is reported.
//  Sits between the host/command logic and the external serial pins, clocked from CLK_40.
// PARAMETERS
//  DATA_BITS  8  data bits per frame, 5..8, sent LSB first
//  PARITY     0  0=none, 1=odd, 2=even
//  STOP_BITS  1  1 or 2 stop bits on TX; RX checks the first stop bit only
//  TX_DEPTH   4  TX FIFO entries, power of 2, >=2
//  RX_DEPTH   4  RX FIFO entries, power of 2, >=2
// PORTS
//  CLK_40          in   1          system clock, all logic on rising edge
//  reset           in   1          synchronous, active-high
//  baud_rate       in   16         CLK_40 cycles per bit; must be >=4; latched at each frame start
//  tx              out  1          serial out, idle high
//  tx_data         in   DATA_BITS  byte to queue
//  tx_data_strobe  in   1          1-cycle push of tx_data into the TX FIFO
//  tx_full         out  1          TX FIFO full; a push while full is dropped
//  tx_busy         out  1          frame in flight OR TX FIFO non-empty
//  rx              in   1          serial in, asynchronous
//  rx_data         out  DATA_BITS  RX FIFO head (first-word-fall-through)
//  rx_perr         out  1          parity error flag of the head entry
//  rx_ferr         out  1          framing error flag of the head entry
//  rx_valid        out  1          RX FIFO non-empty
//  rx_read         in   1          pop the head entry; ignored when rx_valid=0
//  rx_overrun      out  1          1-cycle pulse when a received byte is dropped because the RX FIFO is full
// BEHAVIOUR
//  Reset values:
//  - tx=1; tx_busy, tx_full, rx_valid, rx_perr, rx_ferr and rx_overrun = 0; rx_data = 0.
//  - Both FIFOs are emptied and both FSMs go to IDLE.
//  - Reset mid-frame aborts the frame; tx=1 from the next edge.
//  FIFOs:
//  - Registered count/pointers; pointers wrap modulo the FIFO depth.
//  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged and both take effect.
//  - A push on a full FIFO, or a pop on an empty one, is ignored.
//  TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE
//  - IDLE: on the edge where the TX FIFO is non-empty, pop the FIFO, latch baud_rate and go to START.
//  - tx goes low on the next edge. A strobe at edge N into an empty FIFO and idle FSM gives tx=0 after edge N+2.
//  - Each bit is held exactly baud_rate cycles.
//  - The parity bit makes the count of ones over data+parity odd (PARITY=1) or even (PARITY=2).
//  - STOP drives 1 for STOP_BITS*baud_rate cycles. If the FIFO is non-empty at the end of STOP, the next START follows with no idle gap.
//  RX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE
//  - rx passes through a 2-FF synchroniser; all sampling uses the synchronised value.
//  - IDLE: on a 1->0 transition, latch baud_rate and go to START.
//  - START: wait baud_rate/2 (floor) cycles, then resample. If 1, this is a false start: return to IDLE, nothing is written.
//  - DATA, PARITY, STOP: sample every baud_rate cycles after the start-bit midpoint.
//  - Mismatched parity sets perr. A stop sample of 0 sets ferr.
//  - On the stop-bit sample the byte and its flags are written to the RX FIFO and the FSM returns to IDLE that cycle. A new start is then detectable immediately.
//  - If the RX FIFO is full at the write, the byte is discarded and rx_overrun pulses for that one cycle. FIFO contents are unchanged.
//  Width and mode rules:
//  - Bit counters are sized for DATA_BITS; the baud counter is 16 bits.
//  - Changing baud_rate mid-frame has no effect until the next frame.
// TESTING
//  1. DATA_BITS=8, PARITY=2, baud_rate=8, tx looped to rx. Push 0xC1.
//     -> tx emits 0,1,0,0,0,0,0,1,1,1(parity),1(stop), each bit 8 cycles, 88 cycles total.
//     -> rx_valid rises with rx_data=0xC1, rx_perr=0, rx_ferr=0.
//     -> tx_busy falls after the stop bit.
//  2. TX_DEPTH=4, line idle. Push 6 bytes 0x01..0x06 on consecutive cycles.
//     -> tx_full=1 after the 5th push; the 6th is dropped.
//     -> Exactly 5 frames 0x01..0x05 are sent in order, back-to-back.
//  3. Drive rx with 0x55 and the parity bit inverted, then 0xAA with stop bit=0.
//     -> First entry: rx_data=0x55, rx_perr=1, rx_ferr=0.
//     -> Second entry: rx_data=0xAA, rx_ferr=1.
//  4. RX_DEPTH=4, no rx_read. Send 5 frames 0x10..0x14.
//     -> A single rx_overrun pulse on the 5th stop sample.
//     -> Reads then return 0x10..0x13 and rx_valid falls.
//  5. baud_rate=8. 2-cycle low glitch on rx.
//     -> RX returns to IDLE, no FIFO write.
//     -> A valid frame sent afterwards is received correctly.
//  6. Assert reset for 1 cycle mid-DATA on TX with 2 bytes queued.
//     -> tx=1 next edge, tx_busy=0, tx_full=0, no further frames.
//     -> A fresh push afterwards is transmitted normally.

Source files
------------

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : Parametrised UART with TX/RX FIFOs and per-byte parity/framing flags.
// Revision : 1.0
// ============================================================================

module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module uart_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 CLK_40,
  input  logic                 reset,
  input  logic [15:0]          baud_rate,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_data_strobe,
  output logic                 tx_full,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_read,
  output logic                 rx_overrun
);
  localparam int   BW      = $clog2(DATA_BITS);
  localparam logic HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- TX ----------------
  state_e               tx_state_q, tx_state_d;
  logic [15:0]          tx_baud_q, tx_baud_d, tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 txf_pop, txf_empty, txf_full, tx_load, tx_bit_end;
  logic [DATA_BITS-1:0] txf_rdata;

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(CLK_40), .rst_i(reset), .push_i(tx_data_strobe), .wdata_i(tx_data),
    .pop_i(txf_pop), .rdata_o(txf_rdata), .empty_o(txf_empty), .full_o(txf_full)
  );

  assign tx_bit_end = (tx_cnt_q == tx_baud_q - 16'd1);

  // tx_d is the line level for the current state; registering it gives the
  // one-cycle lag between the FIFO pop and the start bit on the pin.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = 1'b1;
    tx_load    = 1'b0;
    txf_pop    = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_load  = !txf_empty;
      end
      S_START: begin
        tx_d = 1'b0;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_stop_d  = 1'b0;
          if (tx_bit_q == BW'(DATA_BITS-1)) tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_d = tx_par_q;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (STOP_BITS == 2 && !tx_stop_q) begin
            tx_stop_d = 1'b1;
          end else begin
            tx_state_d = S_IDLE;
            tx_load    = !txf_empty;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load) begin
      txf_pop    = 1'b1;
      tx_baud_d  = baud_rate;
      tx_shift_d = txf_rdata;
      tx_par_d   = par_bit(txf_rdata);
      tx_cnt_d   = '0;
      tx_state_d = S_START;
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_full = txf_full;
  assign tx_busy = (tx_state_q != S_IDLE) || !txf_empty;

  // ---------------- RX ----------------
  state_e               rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0]          rx_baud_q, rx_baud_d, rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ovr_q;
  logic                 rxf_push, rxf_full, rxf_empty, rx_bit_end, rx_half_end;
  logic [DATA_BITS+1:0] rxf_wdata, rxf_rdata;

  uart_fifo_buf #(.WIDTH(DATA_BITS+2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(CLK_40), .rst_i(reset), .push_i(rxf_push), .wdata_i(rxf_wdata),
    .pop_i(rx_read), .rdata_o(rxf_rdata), .empty_o(rxf_empty), .full_o(rxf_full)
  );

  assign rx_bit_end  = (rx_cnt_q == rx_baud_q - 16'd1);
  assign rx_half_end = (rx_cnt_q == (rx_baud_q >> 1) - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rxf_push   = 1'b0;
    rxf_wdata  = {1'b0, rx_perr_q, rx_shift_q};
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_baud_d  = baud_rate;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_half_end) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BW'(DATA_BITS-1)) rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_perr_d  = (rx_s2_q != par_bit(rx_shift_q));
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rxf_push   = 1'b1;
          rxf_wdata  = {!rx_s2_q, rx_perr_q, rx_shift_q};
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rxf_push && rxf_full;
    end
  end

  // Head fields are masked while empty so stale storage never shows.
  assign rx_valid   = !rxf_empty;
  assign rx_data    = rx_valid ? rxf_rdata[DATA_BITS-1:0] : '0;
  assign rx_perr    = rx_valid && rxf_rdata[DATA_BITS];
  assign rx_ferr    = rx_valid && rxf_rdata[DATA_BITS+1];
  assign rx_overrun = rx_ovr_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo
// Purpose  : Directed self-checking bench for uart_fifo (8 data bits, even parity).
// Revision : 1.0
// ============================================================================

module tb_uart_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_rate = 16'd8;
  logic        tx;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_data_strobe = 1'b0;
  logic        tx_full, tx_busy;
  logic        rx_line, rx_drv = 1'b1, loop_en = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid, rx_overrun;
  logic        rx_read = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  logic rec_en = 1'b0;
  logic txlog[$];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .CLK_40(clk), .reset(reset), .baud_rate(baud_rate), .tx(tx),
    .tx_data(tx_data), .tx_data_strobe(tx_data_strobe), .tx_full(tx_full),
    .tx_busy(tx_busy), .rx(rx_line), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .rx_valid(rx_valid), .rx_read(rx_read), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec_en) txlog.push_back(tx);
    if (rx_overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int first_zero(input int from);
    for (int k = from; k < txlog.size(); k++) if (txlog[k] == 1'b0) return k;
    return -1;
  endfunction

  // Mismatching cycles of an 88-cycle frame (start, 8 data LSB first, even parity, stop).
  function automatic int frame_errs(input int start, input logic [7:0] d);
    logic [10:0] bits;
    int e;
    e = 0;
    bits = {1'b1, ^d, d, 1'b0};
    for (int k = 0; k < 88; k++)
      if (start + k >= txlog.size() || txlog[start + k] !== bits[k / 8]) e++;
    return e;
  endfunction

  task automatic push(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_data_strobe = 1'b1;
    @(negedge clk); tx_data_strobe = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); rx_read = 1'b1;
    @(negedge clk); rx_read = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pflip, input logic stopv);
    logic [10:0] bits;
    bits = {stopv, (^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); rx_drv = bits[i];
      repeat (7) @(negedge clk);
    end
    @(negedge clk); rx_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n;
    n = 0;
    while (!rx_valid && n < maxc) begin @(negedge clk); n++; end
    chk(tag, rx_valid, 1);
  endtask

  task automatic start_rec();
    @(posedge clk);
    txlog.delete();
    rec_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {rx_perr, rx_ferr, rx_overrun}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: loopback 0xC1
    loop_en = 1'b1;
    start_rec();
    push(8'hC1);
    repeat (40) @(negedge clk);
    chk("t1_busy_mid", tx_busy, 1);
    repeat (60) @(negedge clk);
    chk("t1_busy_end", tx_busy, 0);
    rec_en = 1'b0;
    chk("t1_latency", first_zero(0), 3);
    chk("t1_frame", frame_errs(3, 8'hC1), 0);
    wait_valid("t1_valid", 50);
    chk("t1_data", rx_data, 8'hC1);
    chk("t1_perr", rx_perr, 0);
    chk("t1_ferr", rx_ferr, 0);
    pop();
    chk("t1_empty", rx_valid, 0);
    loop_en = 1'b0;

    // 2: burst of 6 into a 4-deep FIFO
    start_rec();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) chk("t2_notfull", tx_full, 0);
      if (i == 6) chk("t2_full", tx_full, 1);
      tx_data = 8'(i); tx_data_strobe = 1'b1;
    end
    @(negedge clk); tx_data_strobe = 1'b0;
    repeat (600) @(negedge clk);
    rec_en = 1'b0;
    begin
      int idx;
      idx = first_zero(0);
      chk("t2_first", idx, 3);
      for (int f = 0; f < 5; f++) chk($sformatf("t2_frame%0d", f + 1), frame_errs(idx + 88 * f, 8'(f + 1)), 0);
      chk("t2_no6th", first_zero(idx + 440), 32'hFFFF_FFFF);
    end
    chk("t2_idle_busy", tx_busy, 0);

    // 3: parity error then framing error
    send_rx(8'h55, 1'b1, 1'b1);
    send_rx(8'hAA, 1'b0, 1'b0);
    wait_valid("t3_valid", 20);
    chk("t3_d0", rx_data, 8'h55);
    chk("t3_perr0", rx_perr, 1);
    chk("t3_ferr0", rx_ferr, 0);
    pop();
    chk("t3_d1", rx_data, 8'hAA);
    chk("t3_ferr1", rx_ferr, 1);
    chk("t3_perr1", rx_perr, 0);
    pop();
    chk("t3_empty", rx_valid, 0);

    // 4: overrun on the fifth frame
    ovr_cnt = 0;
    for (int f = 0; f < 4; f++) send_rx(8'h10 + 8'(f), 1'b0, 1'b1);
    chk("t4_no_ovr", ovr_cnt, 0);
    send_rx(8'h14, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("t4_ovr", ovr_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_rd%0d", i), rx_data, 8'h10 + 8'(i));
      pop();
    end
    chk("t4_empty", rx_valid, 0);

    // 5: 2-cycle glitch is a false start
    @(negedge clk); rx_drv = 1'b0;
    repeat (2) @(negedge clk); rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_nowrite", rx_valid, 0);
    send_rx(8'h3C, 1'b0, 1'b1);
    wait_valid("t5_valid", 20);
    chk("t5_data", rx_data, 8'h3C);
    chk("t5_flags", {rx_perr, rx_ferr}, 0);
    pop();

    // 6: reset mid-frame with two bytes queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tx_data = 8'hE0 + 8'(i); tx_data_strobe = 1'b1;
    end
    @(negedge clk); tx_data_strobe = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_busy_pre", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("t6_tx", tx, 1);
    chk("t6_busy", tx_busy, 0);
    chk("t6_full", tx_full, 0);
    start_rec();
    repeat (200) @(negedge clk);
    rec_en = 1'b0;
    chk("t6_silent", first_zero(0), 32'hFFFF_FFFF);
    start_rec();
    push(8'h5A);
    repeat (100) @(negedge clk);
    rec_en = 1'b0;
    chk("t6_latency", first_zero(0), 3);
    chk("t6_frame", frame_errs(3, 8'h5A), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
